// File: rtl/gpio_input_poller_pkg.sv
// gpio_input_poller_pkg: poll FSM states and gpio_controller register offsets
package gpio_input_poller_pkg;
  typedef enum logic [2:0] {INIT, IDLE, READ_REQ, READ_WAIT, UPDATE} gpio_poll_state_t;
  localparam logic [31:0] GPIO_DIRECTION_OFFSET = 32'd0;
  localparam logic [31:0] GPIO_VALUE_OFFSET = 32'd4;
endpackage

// File: rtl/io_bus_interface.sv
// io_bus_interface: single-beat register bus with one-cycle read latency
interface io_bus_interface;
  logic [31:0] address;
  logic write_en;
  logic [31:0] write_data;
  logic read_en;
  logic [31:0] read_data;
  modport master(output address, write_en, write_data, read_en, input read_data);
  modport slave(input address, write_en, write_data, read_en, output read_data);
endinterface

// File: rtl/gpio_input_poller_debounce_pin.sv
// gpio_debounce_pin: per-poll debouncer for one pin with edge detection
module gpio_debounce_pin #(
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic update,
  input  logic raw,
  output logic debounced,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] DC = CW'(DEBOUNCE_COUNT);
  logic prev_raw;
  logic [CW-1:0] stable_cnt, cnt_next;
  logic apply;
  always_comb begin
    cnt_next = raw != prev_raw ? CW'(1) : stable_cnt == DC ? DC : stable_cnt + 1'b1;
    apply = update && cnt_next >= DC && raw != debounced;
    rise = apply && raw;
    fall = apply && !raw;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_raw <= 1'b0;
      stable_cnt <= '0;
      debounced <= 1'b0;
    end else if (update) begin
      prev_raw <= raw;
      stable_cnt <= cnt_next;
      if (apply) debounced <= raw;
    end
  end
endmodule

// File: rtl/gpio_input_poller.sv
// gpio_input_poller: polls a gpio_controller over io_bus, debounces pins, latches edge interrupts
module gpio_input_poller
  import gpio_input_poller_pkg::*;
#(
  parameter logic [31:0] GPIO_BASE = 32'd0,
  parameter int NUM_PINS = 8,
  parameter int POLL_INTERVAL = 1000,
  parameter int DEBOUNCE_COUNT = 3,
  parameter logic [31:0] DIRECTION_INIT = 32'd0
) (
  input  logic clk,
  input  logic reset,
  io_bus_interface.master io_bus,
  input  logic [NUM_PINS-1:0] rise_en,
  input  logic [NUM_PINS-1:0] fall_en,
  input  logic clear_en,
  input  logic [NUM_PINS-1:0] clear_mask,
  output logic [NUM_PINS-1:0] debounced,
  output logic [NUM_PINS-1:0] pending,
  output logic gpio_irq,
  output logic sample_strobe
);
  localparam int CW = $clog2(POLL_INTERVAL);
  gpio_poll_state_t state;
  logic [CW-1:0] cnt;
  logic tick, update;
  logic [NUM_PINS-1:0] raw, rise, fall, set;
  always_comb begin
    tick = cnt == CW'(POLL_INTERVAL - 1);
    update = state == UPDATE;
    set = (rise & rise_en) | (fall & fall_en);
  end
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_debounce_pin #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_pin (
      .clk(clk), .reset(reset), .update(update), .raw(raw[i]),
      .debounced(debounced[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      raw <= '0;
      io_bus.address <= '0;
      io_bus.write_en <= 1'b0;
      io_bus.write_data <= '0;
      io_bus.read_en <= 1'b0;
      sample_strobe <= 1'b0;
      pending <= '0;
      gpio_irq <= 1'b0;
    end else begin
      assert (!tick || state == IDLE);
      cnt <= tick ? '0 : cnt + 1'b1;
      io_bus.address <= GPIO_BASE + GPIO_VALUE_OFFSET;
      io_bus.write_en <= 1'b0;
      io_bus.write_data <= '0;
      io_bus.read_en <= 1'b0;
      sample_strobe <= 1'b0;
      pending <= (pending & ~(clear_en ? clear_mask : '0)) | set;
      gpio_irq <= |pending;
      case (state)
        INIT: begin
          io_bus.address <= GPIO_BASE + GPIO_DIRECTION_OFFSET;
          io_bus.write_en <= 1'b1;
          io_bus.write_data <= DIRECTION_INIT;
          state <= IDLE;
        end
        IDLE: if (tick) begin
          io_bus.read_en <= 1'b1;
          state <= READ_REQ;
        end
        READ_REQ: state <= READ_WAIT;
        READ_WAIT: begin
          raw <= io_bus.read_data[NUM_PINS-1:0];
          sample_strobe <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_input_poller.sv
// tb_gpio_input_poller: randomized poll stimulus against a poll-history reference model
module tb_gpio_input_poller;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int PI = 16;
  localparam int DC = 3;
  logic clk = 0, reset = 1;
  logic [7:0] rise_en = 0, fall_en = 0, clear_mask = 0, pins = 0;
  logic clear_en = 0;
  logic [7:0] debounced, pending;
  logic gpio_irq, sample_strobe;
  io_bus_interface bus();
  gpio_input_poller #(.GPIO_BASE(BASE), .NUM_PINS(8), .POLL_INTERVAL(PI), .DEBOUNCE_COUNT(DC),
    .DIRECTION_INIT(32'h0F)) dut (
    .clk(clk), .reset(reset), .io_bus(bus), .rise_en(rise_en), .fall_en(fall_en),
    .clear_en(clear_en), .clear_mask(clear_mask), .debounced(debounced), .pending(pending),
    .gpio_irq(gpio_irq), .sample_strobe(sample_strobe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.read_data <= (bus.read_en && bus.address == BASE + 4) ? {24'hA5C3E1, pins} : 32'h0;
  int cyc = 0, wr_cnt = 0, wr_exp = 0, tests = 0, failed = 0, last_rd = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.write_en === 1'b1) wr_cnt++;
  logic [7:0] hist[$];
  logic [7:0] m_db = 0, m_pend = 0;

  task automatic model_reset();
    hist.delete();
    m_db = 0;
    m_pend = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    tests++; if ({bus.write_en, bus.read_en, sample_strobe, gpio_irq} !== 4'b0 || bus.address !== 0 || bus.write_data !== 0) begin failed++; $display("FAIL reset_bus: we=%b re=%b ss=%b irq=%b addr=%h wd=%h want all 0", bus.write_en, bus.read_en, sample_strobe, gpio_irq, bus.address, bus.write_data); end
    tests++; if (debounced !== 0 || pending !== 0) begin failed++; $display("FAIL reset_state: db=%h pend=%h want 00 00", debounced, pending); end
    reset = 0;
    last_rd = cyc;
    model_reset();
    wr_exp++;
    @(negedge clk);
    tests++; if (bus.write_en !== 1 || bus.address !== BASE || bus.write_data !== 32'h0F) begin failed++; $display("FAIL init_write: we=%b addr=%h wd=%h want 1 %h 0000000f", bus.write_en, bus.address, bus.write_data, BASE); end
  endtask

  task automatic poll(input logic [7:0] v, input logic [7:0] re, input logic [7:0] fe, input logic clr, input logic [7:0] mask);
    int n = 0;
    bit same;
    logic [7:0] nd, set, np;
    pins = v; rise_en = re; fall_en = fe;
    while (bus.read_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests++; if (bus.read_en !== 1'b1) begin failed++; $display("FAIL poll_timeout: no read_en within 40 cycles"); return; end
    tests++; if (bus.address !== BASE + 4 || bus.write_en !== 0) begin failed++; $display("FAIL poll_addr: addr=%h we=%b want %h 0", bus.address, bus.write_en, BASE + 4); end
    tests++; if (cyc - last_rd != PI) begin failed++; $display("FAIL poll_interval: got %0d want %0d", cyc - last_rd, PI); end
    last_rd = cyc;
    hist.push_back(v);
    if (hist.size() > DC) void'(hist.pop_front());
    nd = m_db;
    if (hist.size() == DC) for (int i = 0; i < 8; i++) begin
      same = 1;
      foreach (hist[k]) if (hist[k][i] != v[i]) same = 0;
      if (same) nd[i] = v[i];
    end
    set = (nd & ~m_db & re) | (~nd & m_db & fe);
    np = (m_pend & ~(clr ? mask : 8'h0)) | set;
    @(negedge clk);
    tests++; if (sample_strobe !== 0) begin failed++; $display("FAIL strobe_early: got %b want 0", sample_strobe); end
    @(negedge clk);
    tests++; if (sample_strobe !== 1) begin failed++; $display("FAIL strobe: got %b want 1", sample_strobe); end
    clear_en = clr; clear_mask = mask;
    @(negedge clk);
    clear_en = 0;
    tests++; if (sample_strobe !== 0 || debounced !== nd || pending !== np) begin failed++; $display("FAIL poll_result: ss=%b db=%h pend=%h want 0 %h %h", sample_strobe, debounced, pending, nd, np); end
    tests++; if (gpio_irq !== |m_pend) begin failed++; $display("FAIL irq_lag: got %b want %b", gpio_irq, |m_pend); end
    m_db = nd; m_pend = np;
    @(negedge clk);
    tests++; if (gpio_irq !== |m_pend) begin failed++; $display("FAIL irq: got %b want %b", gpio_irq, |m_pend); end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_poll_interval();
    repeat (3) poll(8'h00, 8'hFF, 8'hFF, 0, 8'h00);
  endtask

  task automatic test_rise();
    do_reset();
    repeat (4) poll(8'h00, 8'h01, 8'h00, 0, 8'h00);
    poll(8'h01, 8'h01, 8'h00, 0, 8'h00);
    poll(8'h01, 8'h01, 8'h00, 0, 8'h00);
    tests++; if (debounced[0] !== 0) begin failed++; $display("FAIL rise_early: db0=%b want 0", debounced[0]); end
    poll(8'h01, 8'h01, 8'h00, 0, 8'h00);
    tests++; if (debounced[0] !== 1 || pending[0] !== 1 || gpio_irq !== 1) begin failed++; $display("FAIL rise_poll7: db0=%b pend0=%b irq=%b want 1 1 1", debounced[0], pending[0], gpio_irq); end
  endtask

  task automatic test_glitch();
    repeat (2) poll(8'h05, 8'hFF, 8'hFF, 0, 8'h00);
    repeat (3) poll(8'h01, 8'hFF, 8'hFF, 0, 8'h00);
    tests++; if (debounced[2] !== 0 || pending[2] !== 0) begin failed++; $display("FAIL glitch: db2=%b pend2=%b want 0 0", debounced[2], pending[2]); end
  endtask

  task automatic test_clear();
    repeat (3) poll(8'h05, 8'h05, 8'h00, 0, 8'h00);
    tests++; if (pending !== 8'h05) begin failed++; $display("FAIL pend05: got %h want 05", pending); end
    clear_en = 1; clear_mask = 8'h01;
    @(negedge clk);
    clear_en = 0;
    m_pend = m_pend & ~8'h01;
    tests++; if (pending !== 8'h04 || gpio_irq !== 1) begin failed++; $display("FAIL clear: pend=%h irq=%b want 04 1", pending, gpio_irq); end
    @(negedge clk);
    tests++; if (gpio_irq !== 1) begin failed++; $display("FAIL clear_irq: got %b want 1", gpio_irq); end
    repeat (3) poll(8'h04, 8'h00, 8'h00, 0, 8'h00);
    repeat (2) poll(8'h05, 8'h01, 8'h00, 0, 8'h00);
    poll(8'h05, 8'h01, 8'h00, 1, 8'h01);
    tests++; if (pending !== 8'h05) begin failed++; $display("FAIL set_wins: got %h want 05", pending); end
  endtask

  task automatic test_random();
    logic [7:0] v = pins;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) v = v ^ 8'($urandom);
      poll(v, 8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (bus.read_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests++; if (bus.read_en !== 1'b1) begin failed++; $display("FAIL mid_timeout: no read_en within 40 cycles"); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    tests++; if (bus.read_en !== 0 || bus.write_en !== 0 || debounced !== 0 || pending !== 0 || sample_strobe !== 0) begin failed++; $display("FAIL mid_reset: re=%b we=%b db=%h pend=%h ss=%b want 0 0 00 00 0", bus.read_en, bus.write_en, debounced, pending, sample_strobe); end
    reset = 0;
    last_rd = cyc;
    model_reset();
    wr_exp++;
    @(negedge clk);
    tests++; if (bus.write_en !== 1 || bus.address !== BASE || bus.write_data !== 32'h0F) begin failed++; $display("FAIL mid_init: we=%b addr=%h wd=%h want 1 %h 0000000f", bus.write_en, bus.address, bus.write_data, BASE); end
    repeat (3) poll(pins, 8'hFF, 8'hFF, 0, 8'h00);
  endtask

  task automatic test_writes();
    tests++; if (wr_cnt != wr_exp) begin failed++; $display("FAIL write_count: got %0d want %0d", wr_cnt, wr_exp); end
  endtask

  initial begin
    test_reset();
    test_poll_interval();
    test_rise();
    test_glitch();
    test_clear();
    test_random();
    test_reset_mid();
    test_writes();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
